// File: rtl/n64_input_conditioner.sv
// Conditioner for asynchronous active-low N64 control inputs: per-channel synchroniser,
// debounce filter, active-high level and one-cycle assert/release strobes.
module n64_input_conditioner #(
   parameter int CHANNELS      = 2,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] in_n,
   output logic [CHANNELS-1:0] active,
   output logic [CHANNELS-1:0] assert_pulse,
   output logic [CHANNELS-1:0] release_pulse,
   output logic                any_active
);

   localparam int CNT_W = $clog2(FILTER_CYCLES);

   // No handshake: active is a level, the pulses are strobes valid for exactly one
   // cycle, so consumers must sample every cycle.
   logic [CHANNELS-1:0] active_next;

   genvar i;
   generate
      for (i = 0; i < CHANNELS; i++) begin : g_ch
         logic [SYNC_STAGES-1:0] sync_q;
         logic                   s;
         logic                   act_nx;

         // Flops preset to 1 so the channel powers up inactive.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) sync_q <= '1;
            else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_n[i]};
         end

         assign s              = ~sync_q[SYNC_STAGES-1];
         assign active_next[i] = act_nx;

         if (FILTER_CYCLES == 1) begin : g_direct
            assign act_nx = s;
         end else begin : g_filter
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Any sample matching the current level clears the run of differing samples.
            always_comb begin
               cnt_d  = '0;
               act_nx = active[i];
               if (s != active[i]) begin
                  if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) act_nx = s;
                  else                                    cnt_d  = cnt_q + 1'b1;
               end
            end

            always_ff @(posedge clk or posedge reset) begin
               if (reset) cnt_q <= '0;
               else       cnt_q <= cnt_d;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active        <= '0;
         assert_pulse  <= '0;
         release_pulse <= '0;
         any_active    <= 1'b0;
      end else begin
         active        <= active_next;
         assert_pulse  <= active_next & ~active;
         release_pulse <= ~active_next & active;
         any_active    <= |active_next;
      end
   end

endmodule

// File: tb/tb_n64_input_conditioner.sv
// Bench for n64_input_conditioner: default build plus a SYNC_STAGES=3/FILTER_CYCLES=1
// build, both compared every cycle against a window-based behavioural model.
module tb_n64_input_conditioner;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] in_a = 2'b11;
   logic [1:0] in_b = 2'b11;
   logic [1:0] act_a, ap_a, rp_a;
   logic [1:0] act_b, ap_b, rp_b;
   logic       any_a, any_b;

   int tests = 0;
   int fails = 0;
   bit checking = 0;
   int edge_cnt = 0;

   always #5 clk = ~clk;

   n64_input_conditioner #(.CHANNELS(2), .SYNC_STAGES(2), .FILTER_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .in_n(in_a), .active(act_a),
      .assert_pulse(ap_a), .release_pulse(rp_a), .any_active(any_a)
   );

   n64_input_conditioner #(.CHANNELS(2), .SYNC_STAGES(3), .FILTER_CYCLES(1)) dut_fast (
      .clk(clk), .reset(reset), .in_n(in_b), .active(act_b),
      .assert_pulse(ap_b), .release_pulse(rp_b), .any_active(any_b)
   );

   // Model: s is in_n inverted and delayed by SYNC_STAGES edges; the level flips
   // once the last FILTER_CYCLES samples since reset all differ from it.
   int         ss_of[2] = '{2, 3};
   int         fc_of[2] = '{16, 1};
   logic [7:0]  m_pipe[2][2];
   logic [31:0] m_win[2][2];
   int          m_cnt[2][2];
   logic [1:0]  m_act[2], m_ap[2], m_rp[2];

   always @(posedge clk or posedge reset) begin
      logic       s_now;
      logic       all_diff;
      logic [1:0] inv;
      if (reset) begin
         edge_cnt = 0;
         for (int k = 0; k < 2; k++) begin
            m_act[k] = 2'b00; m_ap[k] = 2'b00; m_rp[k] = 2'b00;
            for (int c = 0; c < 2; c++) begin
               m_pipe[k][c] = '1; m_win[k][c] = '0; m_cnt[k][c] = 0;
            end
         end
      end else begin
         edge_cnt++;
         for (int k = 0; k < 2; k++) begin
            inv = (k == 0) ? in_a : in_b;
            for (int c = 0; c < 2; c++) begin
               s_now = ~m_pipe[k][c][ss_of[k]-1];
               m_pipe[k][c] = {m_pipe[k][c][6:0], inv[c]};
               m_win[k][c]  = {m_win[k][c][30:0], s_now};
               if (m_cnt[k][c] < 32) m_cnt[k][c]++;
               all_diff = (m_cnt[k][c] >= fc_of[k]);
               for (int j = 0; j < fc_of[k]; j++)
                  if (m_win[k][c][j] == m_act[k][c]) all_diff = 1'b0;
               m_ap[k][c] = 1'b0;
               m_rp[k][c] = 1'b0;
               if (all_diff) begin
                  m_act[k][c] = ~m_act[k][c];
                  if (m_act[k][c]) m_ap[k][c] = 1'b1;
                  else             m_rp[k][c] = 1'b1;
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   int ap_cnt[2][2], rp_cnt[2][2];

   always @(negedge clk) begin
      for (int c = 0; c < 2; c++) begin
         ap_cnt[0][c] += int'(ap_a[c]); rp_cnt[0][c] += int'(rp_a[c]);
         ap_cnt[1][c] += int'(ap_b[c]); rp_cnt[1][c] += int'(rp_b[c]);
      end
      if (checking) begin
         check("active_a",  act_a, m_act[0]);
         check("assert_a",  ap_a,  m_ap[0]);
         check("release_a", rp_a,  m_rp[0]);
         check("any_a",     any_a, |m_act[0]);
         check("active_b",  act_b, m_act[1]);
         check("assert_b",  ap_b,  m_ap[1]);
         check("release_b", rp_b,  m_rp[1]);
         check("any_b",     any_b, |m_act[1]);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      tick(n);
      reset = 1'b0;
   endtask

   // Waits (bounded) for a channel to reach lvl; returns the edge count or -1.
   task automatic wait_level(input int inst, input int ch, input logic lvl, output int at_edge);
      logic [1:0] a;
      at_edge = -1;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         a = (inst == 0) ? act_a : act_b;
         if (a[ch] == lvl) begin
            at_edge = edge_cnt;
            break;
         end
      end
   endtask

   initial begin
      int e0, at, base_ap, base_rp;
      #1 reset = 1'b1;
      checking = 1;
      tick(3);
      reset = 1'b0;

      // Idle inputs: nothing happens
      tick(100);
      check("idle_active", act_a, 2'b00);
      check("idle_any", any_a, 1'b0);
      check("idle_pulses", ap_cnt[0][0] + ap_cnt[0][1] + rp_cnt[0][0] + rp_cnt[0][1], 0);

      // Input low from before edge 1
      in_a = 2'b10;
      do_reset(2);
      base_ap = ap_cnt[0][0];
      wait_level(0, 0, 1'b1, at);
      check("rise_edge", at, 18);
      check("rise_pulse_now", ap_a, 2'b01);
      tick(5);
      check("rise_pulse_count", ap_cnt[0][0] - base_ap, 1);
      check("ch1_quiet", {act_a[1], ap_cnt[0][1]}, 0);

      // Release: falls 18 edges after the input goes high
      base_rp = rp_cnt[0][0];
      in_a = 2'b11;
      e0 = edge_cnt;
      wait_level(0, 0, 1'b0, at);
      check("fall_latency", at - e0, 18);
      check("fall_any", any_a, 1'b0);
      tick(3);
      check("fall_pulse_count", rp_cnt[0][0] - base_rp, 1);

      // Short pulse rejected, longer one accepted
      base_ap = ap_cnt[0][0];
      in_a = 2'b10; tick(15); in_a = 2'b11; tick(40);
      check("short15_rejected", ap_cnt[0][0] - base_ap, 0);
      base_rp = rp_cnt[0][0];
      in_a = 2'b10; tick(17); in_a = 2'b11; tick(40);
      check("long17_assert", ap_cnt[0][0] - base_ap, 1);
      check("long17_release", rp_cnt[0][0] - base_rp, 1);

      // Asynchronous reset mid-count, then power-up assertion
      in_a = 2'b01; tick(25);
      in_a = 2'b00; tick(12);
      check("pre_reset_active", act_a, 2'b10);
      reset = 1'b1;
      #1;
      check("async_reset_active", act_a, 2'b00);
      check("async_reset_any", any_a, 1'b0);
      tick(2);
      reset = 1'b0;
      wait_level(0, 0, 1'b1, at);
      check("powerup_edge", at, 18);
      check("powerup_both", ap_a, 2'b11);

      // Toggling every cycle never gets through the filter
      in_a = 2'b11;
      do_reset(2);
      base_ap = ap_cnt[0][0] + ap_cnt[0][1];
      for (int i = 0; i < 200; i++) begin
         in_a = (i % 2 == 0) ? 2'b00 : 2'b11;
         tick(1);
      end
      in_a = 2'b11; tick(30);
      check("toggle_no_pulses", ap_cnt[0][0] + ap_cnt[0][1] - base_ap, 0);

      // Fast build: both channels at edge 4 with simultaneous pulses
      in_b = 2'b11; tick(5);
      e0 = edge_cnt;
      in_b = 2'b00;
      wait_level(1, 0, 1'b1, at);
      check("fast_latency", at - e0, 4);
      check("fast_pulses", ap_b, 2'b11);
      check("fast_active", act_b, 2'b11);

      // Random hold lengths on both builds, with one reset somewhere in the middle
      for (int seg = 0; seg < 60; seg++) begin
         in_a = 2'($urandom_range(0, 3));
         in_b = 2'($urandom_range(0, 3));
         tick($urandom_range(1, 24));
         if (seg == 30) begin
            #($urandom_range(1, 6));
            reset = 1'b1;
            tick(2);
            reset = 1'b0;
         end
      end
      tick(40);

      checking = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
